// File: rtl/interrupt_flag_reg_pkg.sv
// interrupt_flag_reg_pkg: shared IRQ constants (IF register address, source indices, source count)
package interrupt_flag_reg_pkg;
  localparam logic [15:0] IF_ADDR_DEF = 16'hFF0F;
  localparam int          NUM_SRC_DEF = 5;
  localparam int          VBLANK      = 0;
  localparam int          STAT        = 1;
  localparam int          TIMER       = 2;
  localparam int          SERIAL      = 3;
  localparam int          JOYPAD      = 4;
endpackage

// File: rtl/interrupt_flag_reg_irq_flag_bit.sv
// irq_flag_bit: one interrupt flag cell with rising-edge set, CPU write and acknowledge clear
// Ports: clk/rst clock and sync reset, src request level, wr write enable, d write bit,
//        ack acknowledge, q registered flag.
module irq_flag_bit (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic wr,
  input  logic d,
  input  logic ack,
  output logic q
);
  logic src_prev;
  logic rise;
  assign rise = src & ~src_prev;
  always_ff @(posedge clk) begin
    src_prev <= src;
    // ack beats a written 1, a fresh edge beats both
    q <= rst ? 1'b0 : (((wr ? d : q) & ~ack) | rise);
  end
endmodule

// File: rtl/interrupt_flag_reg.sv
// interrupt_flag_reg: CPU-visible interrupt flag register with per-source edge capture
// Ports: CLK clock, SYNC_RES sync active-high reset, A/DL_in/DL_out/DL_oe/RD/WR CPU bus,
//        SRC_REQ peripheral request levels, CPU_IRQ_ACK per-bit acknowledge,
//        CPU_IRQ_TRIG pending flags, IRQ_ANY OR of pending flags.
module interrupt_flag_reg
  import interrupt_flag_reg_pkg::*;
#(
  parameter int          NUM_SRC = NUM_SRC_DEF,
  parameter logic [15:0] IF_ADDR = IF_ADDR_DEF
) (
  input  logic               CLK,
  input  logic               SYNC_RES,
  input  logic [15:0]        A,
  input  logic [7:0]         DL_in,
  output logic [7:0]         DL_out,
  output logic               DL_oe,
  input  logic               RD,
  input  logic               WR,
  input  logic [NUM_SRC-1:0] SRC_REQ,
  input  logic [7:0]         CPU_IRQ_ACK,
  output logic [7:0]         CPU_IRQ_TRIG,
  output logic               IRQ_ANY
);
  // unimplemented flag bits read back as 1
  localparam logic [7:0] UNIMP = 8'hFF << NUM_SRC;
  logic               sel;
  logic [NUM_SRC-1:0] if_q;
  assign sel = A == IF_ADDR;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_bit
    irq_flag_bit u_bit (
      .clk(CLK),
      .rst(SYNC_RES),
      .src(SRC_REQ[i]),
      .wr (WR & sel),
      .d  (DL_in[i]),
      .ack(CPU_IRQ_ACK[i]),
      .q  (if_q[i])
    );
  end
  assign CPU_IRQ_TRIG = 8'(if_q);
  assign IRQ_ANY      = |if_q;
  assign DL_oe        = RD & sel;
  assign DL_out       = DL_oe ? (UNIMP | 8'(if_q)) : 8'h00;
endmodule

// File: tb/tb_interrupt_flag_reg.sv
// tb_interrupt_flag_reg: directed self-checking bench for interrupt_flag_reg
module tb_interrupt_flag_reg;
  logic        CLK = 1'b0;
  logic        SYNC_RES;
  logic [15:0] A;
  logic [7:0]  DL_in;
  logic [7:0]  DL_out;
  logic        DL_oe;
  logic        RD;
  logic        WR;
  logic [4:0]  SRC_REQ;
  logic [7:0]  CPU_IRQ_ACK;
  logic [7:0]  CPU_IRQ_TRIG;
  logic        IRQ_ANY;
  int total = 0;
  int bad   = 0;

  interrupt_flag_reg dut (
    .CLK(CLK), .SYNC_RES(SYNC_RES), .A(A), .DL_in(DL_in), .DL_out(DL_out),
    .DL_oe(DL_oe), .RD(RD), .WR(WR), .SRC_REQ(SRC_REQ),
    .CPU_IRQ_ACK(CPU_IRQ_ACK), .CPU_IRQ_TRIG(CPU_IRQ_TRIG), .IRQ_ANY(IRQ_ANY)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    SYNC_RES = 1'b1; A = 16'h0000; DL_in = 8'h00; RD = 1'b0; WR = 1'b0;
    SRC_REQ = 5'b00000; CPU_IRQ_ACK = 8'h00;
    step(); step();
    chk("reset_trig", CPU_IRQ_TRIG, 8'h00);
    chk("reset_any", 8'(IRQ_ANY), 8'h00);
    SYNC_RES = 1'b0;
    step();
    chk("idle_trig", CPU_IRQ_TRIG, 8'h00);
    // timer edge, held high
    SRC_REQ = 5'b00100;
    step();
    chk("timer_set", CPU_IRQ_TRIG, 8'h04);
    chk("timer_any", 8'(IRQ_ANY), 8'h01);
    for (int i = 0; i < 9; i++) step();
    chk("timer_hold", CPU_IRQ_TRIG, 8'h04);
    CPU_IRQ_ACK = 8'h04;
    step();
    CPU_IRQ_ACK = 8'h00;
    chk("ack_clear", CPU_IRQ_TRIG, 8'h00);
    step(); step();
    chk("no_reset_while_held", CPU_IRQ_TRIG, 8'h00);
    chk("no_reset_any", 8'(IRQ_ANY), 8'h00);
    // CPU writes and reads
    A = 16'hFF0F; DL_in = 8'hFF; WR = 1'b1;
    step();
    WR = 1'b0; RD = 1'b1;
    #1;
    chk("rd_ff_oe", 8'(DL_oe), 8'h01);
    chk("rd_ff", DL_out, 8'hFF);
    chk("wr_ff_trig", CPU_IRQ_TRIG, 8'h1F);
    RD = 1'b0; WR = 1'b1; DL_in = 8'h00;
    step();
    WR = 1'b0; RD = 1'b1;
    #1;
    chk("rd_e0", DL_out, 8'hE0);
    // simultaneous read and write returns pre-write value
    WR = 1'b1; DL_in = 8'h03;
    #1;
    chk("rdwr_pre", DL_out, 8'hE0);
    step();
    WR = 1'b0;
    #1;
    chk("rdwr_post", DL_out, 8'hE3);
    RD = 1'b0; WR = 1'b1; DL_in = 8'h00;
    step();
    WR = 1'b0; SRC_REQ = 5'b00000;
    step();
    chk("cleared", CPU_IRQ_TRIG, 8'h00);
    // edge wins over same-cycle ack
    SRC_REQ = 5'b00100; CPU_IRQ_ACK = 8'h04;
    step();
    CPU_IRQ_ACK = 8'h00;
    chk("edge_beats_ack", CPU_IRQ_TRIG, 8'h04);
    // ack wins over same-cycle write of 1
    WR = 1'b1; DL_in = 8'h05; CPU_IRQ_ACK = 8'h01;
    step();
    WR = 1'b0; CPU_IRQ_ACK = 8'h00;
    chk("ack_beats_wr", CPU_IRQ_TRIG, 8'h04);
    // edge during a read shows only next cycle
    RD = 1'b1; SRC_REQ = 5'b01100;
    #1;
    chk("rd_before_edge", DL_out, 8'hE4);
    step();
    chk("rd_after_edge", DL_out, 8'hEC);
    RD = 1'b0;
    // upper ack bits ignored
    CPU_IRQ_ACK = 8'hE0;
    step();
    CPU_IRQ_ACK = 8'h00;
    chk("ack_upper_ignored", CPU_IRQ_TRIG, 8'h0C);
    // upper write bits ignored
    WR = 1'b1; DL_in = 8'hF5;
    step();
    WR = 1'b0;
    chk("wr_10101", CPU_IRQ_TRIG, 8'h15);
    // reset with pending flags and an in-flight write
    SYNC_RES = 1'b1; WR = 1'b1; DL_in = 8'hFF; SRC_REQ = 5'b11111;
    step();
    WR = 1'b0;
    chk("mid_reset_trig", CPU_IRQ_TRIG, 8'h00);
    chk("mid_reset_any", 8'(IRQ_ANY), 8'h00);
    A = 16'hFF0E; RD = 1'b1;
    #1;
    chk("other_addr_oe", 8'(DL_oe), 8'h00);
    chk("other_addr_dout", DL_out, 8'h00);
    RD = 1'b0;
    step();
    SYNC_RES = 1'b0;
    step();
    chk("release_high_src", CPU_IRQ_TRIG, 8'h00);
    step();
    chk("release_high_src2", CPU_IRQ_TRIG, 8'h00);
    chk("release_any", 8'(IRQ_ANY), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/interrupt_flag_reg.md
INTERRUPT_FLAG_REG -- requirements
Module: interrupt_flag_reg

Interface
REQ-001 SHALL have parameter NUM_SRC, default 5, meaning the number of implemented interrupt sources (IF bits 0..NUM_SRC-1).
REQ-002 SHALL have parameter IF_ADDR, default 16'hFF0F, meaning the CPU address of the IF register.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port SYNC_RES  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port A  input  16  CPU address bus.
REQ-006 SHALL have port DL_in  input  8  CPU write data.
REQ-007 SHALL have port DL_out  output  8  CPU read data.
REQ-008 SHALL have port DL_oe  output  1  read-data drive enable.
REQ-009 SHALL have port RD  input  1  CPU read strobe, active-high.
REQ-010 SHALL have port WR  input  1  CPU write strobe, active-high.
REQ-011 SHALL have port SRC_REQ  input  NUM_SRC  peripheral request levels (bit0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad).
REQ-012 SHALL have port CPU_IRQ_ACK  input  8  per-bit acknowledge from the CPU IRQ logic, active-high.
REQ-013 SHALL have port CPU_IRQ_TRIG  output  8  pending-interrupt levels to the CPU IRQ logic.
REQ-014 SHALL have port IRQ_ANY  output  1  OR of all pending flags.

Function
REQ-015 SHALL detect a rising edge per source: edge[i] = SRC_REQ[i] & ~src_prev[i]; src_prev updated every cycle.
REQ-016 SHALL decode sel = (A == IF_ADDR).
REQ-017 SHALL compute next flags as ((WR & sel ? DL_in[NUM_SRC-1:0] : if_q) & ~CPU_IRQ_ACK[NUM_SRC-1:0]) | edge.
REQ-018 SHALL give a same-cycle edge priority over both write and acknowledge (set wins).
REQ-019 SHALL give acknowledge priority over a same-cycle write of 1 to the same bit.
REQ-020 SHALL clear a flag on every cycle its ACK bit is high; a multi-cycle ACK holds it clear unless a new edge arrives.
REQ-021 SHALL assert CPU_IRQ_TRIG[i] = if_q[i] (registered) one cycle after the sampling edge; bits NUM_SRC..7 SHALL be 0.
REQ-022 SHALL assert DL_oe = RD & sel combinationally, and DL_out = {unimplemented bits forced 1, if_q} when DL_oe, else 8'h00.
REQ-023 SHALL return the registered value on a read; an edge in the read cycle is visible only from the next cycle.
REQ-024 SHALL ignore DL_in bits NUM_SRC..7 on write.
REQ-025 SHALL treat RD and WR asserted together with sel as a write plus a read of the pre-write value.
REQ-026 SHALL ignore ACK bits NUM_SRC..7.
REQ-027 SHALL set IRQ_ANY = |if_q.

Reset
REQ-028 SHALL, while SYNC_RES is high, clear if_q to 0 and load src_prev with current SRC_REQ (no spurious edge on release).
REQ-029 SHALL drive CPU_IRQ_TRIG = 8'h00, IRQ_ANY = 0 during and the cycle after reset; DL_out/DL_oe remain combinational.
REQ-030 SHALL abandon any in-flight set, write or ack when SYNC_RES is asserted mid-operation.

Structure
REQ-031 SHALL place IF_ADDR, source-index constants (VBLANK=0 .. JOYPAD=4) and NUM_SRC in the shared irq package used by the CPU IRQ logic.
REQ-032 SHALL implement the per-bit edge/set/clear cell as one sub-module irq_flag_bit, instantiated NUM_SRC times.

Verification
REQ-033 Bench SHALL cover: SRC_REQ 5'b00000 -> 5'b00100 held 10 cycles -> CPU_IRQ_TRIG = 8'h04 after 1 cycle, set once only; ACK 8'h04 one cycle -> 8'h00 next cycle, no re-set while held.
REQ-034 Bench SHALL cover: write A=16'hFF0F DL_in=8'hFF -> read returns 8'hFF, CPU_IRQ_TRIG = 8'h1F; write 8'h00 -> read 8'hE0.
REQ-035 Bench SHALL cover: Timer edge and ACK 8'h04 in same cycle -> bit 2 remains 1; write 8'h01 with ACK 8'h01 same cycle -> bit 0 is 0.
REQ-036 Bench SHALL cover: SRC_REQ 5'b11111 held through SYNC_RES release -> CPU_IRQ_TRIG stays 8'h00.
REQ-037 Bench SHALL cover: SYNC_RES asserted with if_q = 5'b10101 -> 8'h00 next cycle; read at A=16'hFF0E -> DL_oe = 0, DL_out = 8'h00.
